// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N request channels in, one registered beat out.
interface rr_arb_mux_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux (round-robin or fixed priority) with one registered
// output stage; accepts a new beat whenever the output is empty or draining.
module rr_arb_mux #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MODE  = 0
) (
  input logic          clk,
  input logic          rst_n,
  rr_arb_mux_if.slave  bus
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [SELW-1:0]  last_q, last_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     win;
  logic [SELW-1:0]  win_idx;
  logic [SELW-1:0]  cand;
  logic             found;
  logic [WIDTH-1:0] win_data;
  logic             ld;
  logic             xfer;

  assign ld   = !valid_q || bus.out_ready;
  assign xfer = ld && (|win);

  // Visit channels in priority order; the first requester found wins.
  // Round-robin rotates the order to start just after the last winner.
  always_comb begin
    win     = '0;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (MODE == 0) begin
        cand = SELW'((32'(last_q) + 1 + k) % N);
      end else begin
        cand = SELW'(k);
      end
      if (!found && bus.in_valid[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      win_data = win_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{win[i]}});
    end
  end

  always_comb begin
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = win_data;
      sel_d   = win_idx;
      valid_d = 1'b1;
      last_d  = win_idx;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= SELW'(N - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = win & {N{ld}};
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a scoreboard queue of expected beats is filled
// by the driver on each grant and drained by a monitor on each output handshake.
module tb_rr_arb_mux;
  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ch_dat [4];
  beat_t       sb [$];
  beat_t       e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rr_arb_mux_if #(.N(4), .WIDTH(32)) a_if ();
  rr_arb_mux_if #(.N(4), .WIDTH(32)) b_if ();

  rr_arb_mux #(.N(4), .WIDTH(32), .MODE(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  rr_arb_mux #(.N(4), .WIDTH(32), .MODE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  always_comb a_if.in_data = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
  always_comb b_if.in_data = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};

  function automatic logic [1:0] idx(input logic [3:0] oh);
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) idx = 2'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle on DUT A: drive, check the grant at the negedge, queue the expected beat.
  task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                      input string name);
    a_if.in_valid  = v;
    a_if.out_ready = ordy;
    @(negedge clk);
    chk(name, 32'(a_if.in_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000)
      sb.push_back('{sel: idx(exp_rdy), data: ch_dat[idx(exp_rdy)]});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_if.out_valid && a_if.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sel=%0d data=%h expected no beat",
                 a_if.out_sel, a_if.out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_sel", 32'(a_if.out_sel), 32'(e.sel));
        chk("beat_data", a_if.out_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) ch_dat[i] = 32'hC0DE_0000 + 32'(i);
    a_if.in_valid = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = '0; b_if.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_sel", 32'(a_if.out_sel), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while a beat is stalled in the output register
    step(4'b1111, 1'b0, 4'b0001, "pre_rst_grant");
    chk("pre_rst_valid", 32'(a_if.out_valid), 32'd1);
    a_if.in_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("async_rst_data", a_if.out_data, 32'd0);
    chk("async_rst_sel", 32'(a_if.out_sel), 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin rotation with all channels requesting
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 1'b1, 4'b0001 << (c % 4), "rr_all");
    end

    // Wrap and skip: last=3
    step(4'b0101, 1'b1, 4'b0001, "wrap_ch0");
    step(4'b0101, 1'b1, 4'b0100, "skip_ch2");
    step(4'b0001, 1'b1, 4'b0001, "only_ch0");

    // Single beat then idle; pointer must stay at 2
    ch_dat[2] = 32'h1234_5678;
    step(4'b0100, 1'b1, 4'b0100, "gap_grant");
    chk("gap_valid_hi", 32'(a_if.out_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 1'b1, 4'b0000, "gap_idle_rdy");
      chk("gap_valid_lo", 32'(a_if.out_valid), 32'd0);
    end
    step(4'b1011, 1'b1, 4'b1000, "gap_last_kept");
    step(4'b0000, 1'b1, 4'b0000, "gap_drain");

    // Stall with DEADBEEF held, ch1 waiting
    ch_dat[0] = 32'hDEAD_BEEF;
    step(4'b0001, 1'b0, 4'b0001, "stall_load");
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b0, 4'b0000, "stall_rdy");
      chk("stall_valid", 32'(a_if.out_valid), 32'd1);
      chk("stall_data", a_if.out_data, 32'hDEAD_BEEF);
      chk("stall_sel", 32'(a_if.out_sel), 32'd0);
    end
    step(4'b0010, 1'b1, 4'b0010, "unstall_grant");
    chk("no_bubble_valid", 32'(a_if.out_valid), 32'd1);
    step(4'b0000, 1'b1, 4'b0000, "unstall_drain");
    chk("drained_valid", 32'(a_if.out_valid), 32'd0);

    // Fixed priority on DUT B
    b_if.in_valid  = 4'b1010;
    b_if.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("fp_rdy", 32'(b_if.in_ready), 32'b0010);
      if (b_if.out_valid) begin
        chk("fp_sel", 32'(b_if.out_sel), 32'd1);
        chk("fp_data", b_if.out_data, ch_dat[1]);
      end
      @(posedge clk);
      #1;
    end
    b_if.in_valid = '0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
